// File: rtl/addsub_axis_shim.sv
// AXI-Stream shim around a fixed-latency adder_subtractor: joins the A/B operand streams,
// issues them to the adder and buffers S in a credit-guarded FWFT FIFO.
// Optional TLAST/LAST_MISMATCH support is enabled by defining ADDSUB_SHIM_TLAST_EN.
module addsub_axis_shim #(
  parameter int unsigned A_WIDTH    = 15,
  parameter int unsigned B_WIDTH    = 15,
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 ARESETN,
  input  logic                 S_AXIS_A_TVALID,
  output logic                 S_AXIS_A_TREADY,
  input  logic [A_WIDTH-1:0]   S_AXIS_A_TDATA,
  input  logic                 S_AXIS_B_TVALID,
  output logic                 S_AXIS_B_TREADY,
  input  logic [B_WIDTH-1:0]   S_AXIS_B_TDATA,
  input  logic                 S_AXIS_B_TUSER,
  output logic [A_WIDTH-1:0]   A,
  output logic [B_WIDTH-1:0]   B,
  output logic                 ADD,
  output logic                 CE,
  input  logic [OUT_WIDTH-1:0] S,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic [OUT_WIDTH-1:0] M_AXIS_TDATA
`ifdef ADDSUB_SHIM_TLAST_EN
  ,
  input  logic                 S_AXIS_A_TLAST,
  input  logic                 S_AXIS_B_TLAST,
  output logic                 M_AXIS_TLAST,
  output logic                 LAST_MISMATCH
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic                 ce_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LATENCY:0]     tok_q, tok_d;
  logic [A_WIDTH-1:0]   a_q;
  logic [B_WIDTH-1:0]   b_q;
  logic                 add_q;
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  logic                 out_valid_q;
  logic [OUT_WIDTH-1:0] out_data_q;

  logic credit_ok, fire, pop, capture, mem_empty, load_out, from_mem, bypass, mem_wr;

  // ce_q doubles as "out of reset" so both TREADYs stay low while ARESETN is asserted.
  assign credit_ok       = ce_q && (cnt_q < CW'(FIFO_DEPTH));
  assign S_AXIS_A_TREADY = credit_ok && S_AXIS_B_TVALID;
  assign S_AXIS_B_TREADY = credit_ok && S_AXIS_A_TVALID;
  assign fire            = credit_ok && S_AXIS_A_TVALID && S_AXIS_B_TVALID;
  assign pop             = out_valid_q && M_AXIS_TREADY;
  assign capture         = tok_q[LATENCY];

  assign mem_empty = (wptr_q == rptr_q);
  assign load_out  = !out_valid_q || pop;
  assign from_mem  = load_out && !mem_empty;
  // Straight into the output register when nothing is queued ahead of this result.
  assign bypass    = load_out && mem_empty && capture;
  assign mem_wr    = capture && !bypass;

  assign A             = a_q;
  assign B             = b_q;
  assign ADD           = add_q;
  assign CE            = ce_q;
  assign M_AXIS_TVALID = out_valid_q;
  assign M_AXIS_TDATA  = out_data_q;

  always_comb begin
    tok_d    = '0;
    tok_d[0] = fire;
    for (int unsigned i = 1; i <= LATENCY; i++) begin
      tok_d[i] = tok_q[i-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({fire, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ce_q        <= 1'b0;
      cnt_q       <= '0;
      tok_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      add_q       <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      ce_q  <= 1'b1;
      cnt_q <= cnt_d;
      tok_q <= tok_d;
      if (fire) begin
        a_q   <= S_AXIS_A_TDATA;
        b_q   <= S_AXIS_B_TDATA;
        add_q <= S_AXIS_B_TUSER;
      end
      if (mem_wr) wptr_q <= wptr_q + PW'(1);
      if (from_mem) rptr_q <= rptr_q + PW'(1);
      if (load_out) begin
        if (from_mem) begin
          out_valid_q <= 1'b1;
          out_data_q  <= mem[rptr_q[AW-1:0]];
        end else if (capture) begin
          out_valid_q <= 1'b1;
          out_data_q  <= S;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_wr) mem[wptr_q[AW-1:0]] <= S;
  end

`ifdef ADDSUB_SHIM_TLAST_EN
  logic [LATENCY:0] last_pipe_q, last_pipe_d;
  logic             mem_last [FIFO_DEPTH];
  logic             out_last_q;
  logic             mismatch_q;

  assign M_AXIS_TLAST  = out_last_q;
  assign LAST_MISMATCH = mismatch_q;

  always_comb begin
    last_pipe_d    = '0;
    last_pipe_d[0] = S_AXIS_A_TLAST || S_AXIS_B_TLAST;
    for (int unsigned i = 1; i <= LATENCY; i++) begin
      last_pipe_d[i] = last_pipe_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_pipe_q <= '0;
      out_last_q  <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      last_pipe_q <= last_pipe_d;
      if (fire && (S_AXIS_A_TLAST != S_AXIS_B_TLAST)) mismatch_q <= 1'b1;
      if (from_mem) out_last_q <= mem_last[rptr_q[AW-1:0]];
      else if (bypass) out_last_q <= last_pipe_q[LATENCY];
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_wr) mem_last[wptr_q[AW-1:0]] <= last_pipe_q[LATENCY];
  end
`endif

endmodule

// File: tb/tb_addsub_axis_shim.sv
// Randomized self-checking bench for addsub_axis_shim with a behavioural adder and scoreboard.
module tb_addsub_axis_shim;
  localparam int unsigned AW_    = 15;
  localparam int unsigned BW     = 15;
  localparam int unsigned OW     = 16;
  localparam int unsigned LAT    = 1;
  localparam int unsigned DEPTH  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready, b_valid, b_ready, b_user;
  logic [AW_-1:0] a_data, a_o;
  logic [BW-1:0] b_data, b_o;
  logic          add_o, ce_o;
  logic [OW-1:0] s;
  logic          m_valid, m_ready;
  logic [OW-1:0] m_data;
`ifdef ADDSUB_SHIM_TLAST_EN
  logic          a_last, b_last, m_last, mm_dut;
  logic          mm_model;
`endif

  always #5 clk = ~clk;

  addsub_axis_shim #(
    .A_WIDTH(AW_), .B_WIDTH(BW), .OUT_WIDTH(OW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(clk), .ARESETN(rst_n),
    .S_AXIS_A_TVALID(a_valid), .S_AXIS_A_TREADY(a_ready), .S_AXIS_A_TDATA(a_data),
    .S_AXIS_B_TVALID(b_valid), .S_AXIS_B_TREADY(b_ready), .S_AXIS_B_TDATA(b_data),
    .S_AXIS_B_TUSER(b_user),
    .A(a_o), .B(b_o), .ADD(add_o), .CE(ce_o), .S(s),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data)
`ifdef ADDSUB_SHIM_TLAST_EN
    ,
    .S_AXIS_A_TLAST(a_last), .S_AXIS_B_TLAST(b_last),
    .M_AXIS_TLAST(m_last), .LAST_MISMATCH(mm_dut)
`endif
  );

  // Stand-in for the one-stage adder_subtractor.
  always_ff @(posedge clk) begin
    if (ce_o) s <= add_o ? ({1'b0, a_o} + {1'b0, b_o}) : ({1'b0, a_o} - {1'b0, b_o});
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: one entry per accepted operand pair, {tlast, sum}.
  logic [OW:0]   exp_q[$];
  logic [OW:0]   e;
  logic [OW-1:0] ev, held, last_pop;
  logic          mon_en = 1'b0, last_fire = 1'b0, hold_pend = 1'b0, lastbit;
  int            n_fire = 0, n_pop = 0;

  always @(negedge clk) begin
    last_fire = rst_n && a_valid && a_ready && b_valid && b_ready;
    if (mon_en) begin
      check("a_tready", a_ready, (exp_q.size() < DEPTH) && b_valid);
      check("b_tready", b_ready, (exp_q.size() < DEPTH) && a_valid);
      if (hold_pend) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, held);
      end
      if (!m_valid) check("idle_data", m_data, last_pop);
`ifdef ADDSUB_SHIM_TLAST_EN
      check("last_mismatch", mm_dut, mm_model);
`endif
      if (m_valid && m_ready) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", m_data, e[OW-1:0]);
`ifdef ADDSUB_SHIM_TLAST_EN
          check("out_tlast", m_last, e[OW]);
`endif
        end
        last_pop = m_data;
        n_pop++;
      end
      if (last_fire) begin
        ev = b_user ? (OW'(a_data) + OW'(b_data)) : (OW'(a_data) - OW'(b_data));
        lastbit = 1'b0;
`ifdef ADDSUB_SHIM_TLAST_EN
        lastbit = a_last | b_last;
        if (a_last != b_last) mm_model = 1'b1;
`endif
        exp_q.push_back({lastbit, ev});
        n_fire++;
      end
      hold_pend = m_valid && !m_ready;
      held      = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    exp_q.delete();
    hold_pend = 1'b0;
    last_pop  = '0;
`ifdef ADDSUB_SHIM_TLAST_EN
    mm_model = 1'b0;
`endif
  endtask

  // AXIS-compliant source: a pair only changes after it has been accepted.
  task automatic drive(input int cycles, input int pv, input int pr);
    for (int c = 0; c < cycles; c++) begin
      if (!a_valid || last_fire) begin
        a_valid = ($urandom_range(99) < pv);
        a_data  = AW_'($urandom);
`ifdef ADDSUB_SHIM_TLAST_EN
        a_last  = ($urandom_range(7) == 0);
`endif
      end
      if (!b_valid || last_fire) begin
        b_valid = ($urandom_range(99) < pv);
        b_data  = BW'($urandom);
        b_user  = 1'($urandom);
`ifdef ADDSUB_SHIM_TLAST_EN
        b_last  = ($urandom_range(7) == 0);
`endif
      end
      m_ready = ($urandom_range(99) < pr);
      step();
    end
  endtask

  task automatic single(input logic [AW_-1:0] a, input logic [BW-1:0] b, input logic u,
                        input logic [OW-1:0] want);
    a_data = a; b_data = b; b_user = u; a_valid = 1'b1; b_valid = 1'b1; m_ready = 1'b1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check("lat_edge1_valid", m_valid, 0);
    step();
    check("lat_edge2_valid", m_valid, 0);
    step();
    check("lat_edge3_valid", m_valid, 1);
    check("lat_edge3_data", m_data, want);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (got running, expected done)");
    $fatal(1);
  end

  int f0, p0;

  initial begin
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; b_user = 1'b1; m_ready = 1'b1;
    a_data = 15'h1234; b_data = 15'h0321;
`ifdef ADDSUB_SHIM_TLAST_EN
    a_last = 1'b0; b_last = 1'b0; mm_model = 1'b0;
`endif
    flush_model();
    #3;
    check("rst_a", a_o, 0);
    check("rst_b", b_o, 0);
    check("rst_add", add_o, 0);
    check("rst_ce", ce_o, 0);
    check("rst_tvalid", m_valid, 0);
    check("rst_tdata", m_data, 0);
    check("rst_a_tready", a_ready, 0);
    check("rst_b_tready", b_ready, 0);
`ifdef ADDSUB_SHIM_TLAST_EN
    check("rst_tlast", m_last, 0);
    check("rst_mismatch", mm_dut, 0);
`endif
    a_valid = 1'b0; b_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); step();
    mon_en = 1'b1;
    check("ce_after_reset", ce_o, 1);

    // Basic add / subtract with latency check.
    single(15'd5, 15'd3, 1'b1, 16'd8);
    single(15'd5, 15'd3, 1'b0, 16'd2);

    // 16 back-to-back pairs, full throughput; pair 2 carries a lone A_TLAST.
    f0 = n_fire; p0 = n_pop; m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_valid = 1'b1; b_valid = 1'b1;
      a_data = AW_'($urandom); b_data = BW'($urandom); b_user = 1'($urandom);
`ifdef ADDSUB_SHIM_TLAST_EN
      a_last = (i == 1); b_last = 1'b0;
`endif
      step();
    end
    a_valid = 1'b0; b_valid = 1'b0;
`ifdef ADDSUB_SHIM_TLAST_EN
    a_last = 1'b0;
    check("mismatch_sticky", mm_dut, 1);
`endif
    check("b2b_fires", n_fire - f0, 16);
    step(); step(); step();
    check("b2b_pops_no_gap", n_pop - p0, 16);
    check("b2b_drained_valid", m_valid, 0);

    // B arrives three cycles after A.
    f0 = n_fire;
    a_valid = 1'b1; a_data = 15'd100; b_data = 15'd40; b_user = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("a_wait_ready", a_ready, 0);
    end
    check("a_wait_nofire", n_fire - f0, 0);
    b_valid = 1'b1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check("a_wait_one_fire", n_fire - f0, 1);
    step(); step(); step(); step();

    // Credit exhaustion under backpressure, then drain and resume.
    f0 = n_fire;
    drive(12, 100, 0);
    check("credit_fires", n_fire - f0, DEPTH);
    check("credit_a_ready", a_ready, 0);
    check("credit_b_ready", b_ready, 0);
    drive(20, 100, 100);
    check("credit_resumed", n_fire - f0 > DEPTH, 1);
    a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("credit_drained", exp_q.size(), 0);

    // Random traffic with random backpressure.
    drive(400, 70, 60);
    a_valid = 1'b0; b_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("random_drained", exp_q.size(), 0);

    // Reset with three results buffered.
    f0 = n_fire;
    m_ready = 1'b0;
    drive(3, 100, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    step(); step(); step();
    check("pre_reset_fires", n_fire - f0, 3);
    check("pre_reset_valid", m_valid, 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", m_valid, 0);
    check("mid_reset_data", m_data, 0);
    flush_model();
    step(); step();
    rst_n = 1'b1;
    step(); step();
    mon_en = 1'b1;
`ifdef ADDSUB_SHIM_TLAST_EN
    check("mismatch_cleared", mm_dut, 0);
`endif
    p0 = n_pop;
    m_ready = 1'b1;
    a_data = 15'd7; b_data = 15'd9; b_user = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    for (int i = 0; i < 10 && n_pop == p0; i++) step();
    check("post_reset_pop", n_pop - p0, 1);
    check("post_reset_data", last_pop, 16'd16);
    step(); step(); step();
    check("post_reset_only_one", n_pop - p0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_axis_shim.md
Name: addsub_axis_shim

Overview:
AXI-Stream front/back shim for adder_subtractor. Joins two operand streams (A, B with add/sub select) into one issue per cycle and drives the adder's A/B/ADD/CE ports. Captures S after the adder's configured latency into a credit-guarded result FIFO. Presents S as an AXI-Stream master with full backpressure support, so the fixed-latency adder never stalls.

Parameters:
A_WIDTH, 15, operand A width; must match the adder.
B_WIDTH, 15, operand B width; must match the adder.
OUT_WIDTH, 16, adder S width and M_AXIS_TDATA width.
LATENCY, 1, adder pipeline latency; legal values 0, 1, 2.
FIFO_DEPTH, 4, result FIFO entries; power of 2, at least LATENCY+2.

Ports:
CLK  in  1  system clock, rising edge
ARESETN  in  1  asynchronous active-low reset
S_AXIS_A_TVALID  in  1  operand A valid
S_AXIS_A_TREADY  out  1  operand A ready
S_AXIS_A_TDATA  in  A_WIDTH  operand A
S_AXIS_B_TVALID  in  1  operand B valid
S_AXIS_B_TREADY  out  1  operand B ready
S_AXIS_B_TDATA  in  B_WIDTH  operand B
S_AXIS_B_TUSER  in  1  1 = add, 0 = subtract
A  out  A_WIDTH  to adder A (registered)
B  out  B_WIDTH  to adder B (registered)
ADD  out  1  to adder ADD (registered)
CE  out  1  to adder CE
S  in  OUT_WIDTH  from adder S
M_AXIS_TVALID  out  1  result valid
M_AXIS_TREADY  in  1  downstream ready
M_AXIS_TDATA  out  OUT_WIDTH  result

Behaviour:
- Reset (ARESETN low, asynchronous): A = 0, B = 0, ADD = 0, CE = 0, M_AXIS_TVALID = 0, M_AXIS_TDATA = 0.
- Reset also clears the valid pipeline, FIFO pointers and credit counter. Both TREADYs read 0 during reset.
- After deassertion, CE = 1 permanently; the adder free-runs.
- Credit: cnt = issued-not-yet-captured + FIFO occupancy, range 0..FIFO_DEPTH. credit_ok = (cnt < FIFO_DEPTH).
- S_AXIS_A_TREADY = credit_ok & S_AXIS_B_TVALID.
- S_AXIS_B_TREADY = credit_ok & S_AXIS_A_TVALID.
- fire = both valid & credit_ok; both streams consume together, never one alone.
- On fire at edge k:
  - A, B, ADD are registered from the TDATA/TUSER inputs.
  - A valid token enters a LATENCY-deep shift register.
- S for that operation is sampled at edge k+LATENCY+1 and written to the FIFO.
- LATENCY = 0: S is treated as combinational from the registered A/B, so the FIFO write is at edge k+1.
- When A/B/ADD are not firing they hold their last value; S results with no token are ignored.
- FIFO is first-word-fall-through: M_AXIS_TVALID rises after the write edge when the FIFO was empty. Minimum handshake-to-TVALID latency is LATENCY+1 edges.
- Pop when M_AXIS_TVALID & M_AXIS_TREADY.
- cnt update per cycle:
  - fire only: +1.
  - pop only: −1.
  - fire and pop together: unchanged.
- Because credit is reserved at issue, the FIFO never overflows and S is never dropped.
- Throughput: 1 result per cycle sustained while M_AXIS_TREADY = 1.
- Boundaries:
  - cnt = FIFO_DEPTH: both TREADYs are 0. If a pop occurs that cycle, TREADY stays 0 until the next cycle (no combinational TREADY→TREADY path).
  - FIFO empty: TVALID = 0 and TDATA holds its last value.
  - Pointers wrap modulo FIFO_DEPTH.
  - Once asserted, M_AXIS_TVALID and M_AXIS_TDATA are stable until accepted.
- Arithmetic is done entirely by the adder. The shim passes S unmodified, with no width change.
- Reset mid-operation discards all in-flight and buffered results. After reset, the first output corresponds to the first post-reset fire.

Optional Feature:
Macro ADDSUB_SHIM_TLAST_EN.
- Defined:
  - Ports S_AXIS_A_TLAST, S_AXIS_B_TLAST (in, 1), M_AXIS_TLAST (out, 1) and LAST_MISMATCH (out, 1) exist.
  - TLAST = A_TLAST | B_TLAST, carried alongside its result through the token pipe and FIFO. M_AXIS_TLAST reset value is 0.
  - LAST_MISMATCH is sticky, set on any fire where A_TLAST != B_TLAST, and cleared only by reset.
- Undefined: these ports and their storage are absent.

Test Plan:
- LATENCY=1, A=5, B=3, TUSER=1, M_AXIS_TREADY=1 -> M_AXIS_TDATA=8, TVALID high 2 edges after fire; TUSER=0 -> 2.
- Back-to-back stream of 16 operand pairs, TREADY=1 -> 16 results in order, one per cycle, no gaps.
- M_AXIS_TREADY=0, FIFO_DEPTH=4, continuous operands -> exactly 4 fires, then both TREADYs 0. Release TREADY -> the 4 results drain in order and issue resumes.
- A valid, B valid delayed 3 cycles -> no A consumed until B valid; a single fire with the matching pair.
- Assert ARESETN low with 3 results buffered -> TVALID 0 immediately. After release, the next result is the first new pair only.
- With ADDSUB_SHIM_TLAST_EN: A_TLAST=1, B_TLAST=0 on pair 2 -> M_AXIS_TLAST=1 on result 2, LAST_MISMATCH=1 until reset.
